fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin scheduler that shares one router output channel among N input flit FIFOs.
- Watches each FIFO's empty flag and head item, issues one-hot pop strobes, and captures the granted flit into a single-entry output register.
- The output register uses a valid/ready handshake toward the link or next stage.
- Sits between the per-port input FIFOs and the output link of a router.

Parameters:
- N, 4, number of requesting FIFOs (2..16).
- PTR_W, 2, width of the grant pointer; must equal ceil(log2(N)).
- SIZE, `SIZE (8), flit width in bits; taken from the shared header define.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new grants are issued; a held output still drains.
- fifo_empty  input  N  empty flag of FIFO i on bit i.
- fifo_item  input  N*SIZE  head flit of FIFO i on bits [i*SIZE +: SIZE]; combinational from the FIFO.
- fifo_read  output  N  one-hot pop strobe, combinational, to the FIFO read inputs.
- out_valid  output  1  output register holds a flit.
- out_data  output  SIZE  registered flit.
- out_ready  input  1  downstream accepts the flit this cycle.
- grant_id  output  PTR_W  index of the source of the flit currently in out_data (registered).

Behaviour:
- Reset (async): out_valid=0, out_data=0, grant_id=0, last pointer=N-1 so that requester 0 has first priority. fifo_read=0 while reset is high.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- slot_free = !out_valid | out_ready.
- req = ~fifo_empty.
- Grant condition: enable & slot_free & (req!=0).
  - Winner g is the first set req bit searching last+1, last+2, ... with modulo-N wrap.
  - fifo_read[g]=1 in the same cycle (combinational); all other bits are 0.
  - At the clock edge: out_data<=fifo_item[g], grant_id<=g, out_valid<=1, last<=g.
- Latency: a flit at the FIFO head in cycle t appears on out_data in cycle t+1. Sustained throughput is 1 flit/cycle while out_ready=1.
- Consume without regrant (out_valid & out_ready, but no grant): out_valid<=0; out_data holds its value.
- Stall (out_valid & !out_ready):
  - fifo_read=0 and last is unchanged.
  - out_data and grant_id hold.
- fifo_read is never asserted for an empty FIFO, and never when slot_free=0.
- Fairness: a requester that stays non-empty is granted within N grants.
- A single requester that stays non-empty is granted every cycle; its pointer stays on itself and wraps correctly.
- enable low: no pop occurs; the FULL→EMPTY drain still happens on out_ready.
- Wrap-around: when last=N-1, the search starts at 0.
- Reset mid-transfer: the held flit is discarded and the FIFOs are not popped.
- N not a power of two: the search must skip indices >= N. Pointer arithmetic is modulo N, not modulo 2^PTR_W.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output grant_count, N*16 bits.
  - Per-requester 16-bit saturating counter, incremented on each grant to that requester.
  - Holds at 16'hFFFF once saturated.
  - Cleared to 0 by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header (the same one that provides `SIZE): ARB_N default and the ARB_PTR_W define.
- One natural sub-module, rr_priority_pick:
  - Combinational, parameter N.
  - Inputs req[N] and last[PTR_W].
  - Outputs gnt_onehot[N], gnt_idx[PTR_W], any.
  - Implementation: double-width rotate plus find-first.
- The top level holds the pointer, output register, state and stats counters.

Test Plan:
- Reset then all FIFOs empty, out_ready=1 → fifo_read=0, out_valid=0, out_data=0 for 10 cycles.
- N=4, all four FIFOs loaded with 3 flits each (FIFO i holds i*16+k), out_ready=1 → grant order 0,1,2,3,0,1,2,3,0,1,2,3; one flit per cycle; fifo_read is one-hot each cycle; 12 pops total, then out_valid falls.
- Only FIFO 2 non-empty with 5 flits → 5 consecutive grants to 2; grant_id=2 throughout; data emerges in FIFO order.
- Backpressure: out_ready=0 for 4 cycles while FIFOs 0 and 1 are non-empty → out_data is stable, fifo_read=0, last is unchanged; after release, the next grant goes to the correct round-robin successor.
- enable=0 with out_valid=1, then out_ready=1 → the held flit drains, out_valid=0, and no pop occurs until enable=1.
- Async reset asserted mid-stream between clock edges → out_valid=0 immediately; after release, the first grant goes to requester 0. With ARB_STATS_EN defined, the counters read 0 and then match the grant counts from scenario 2: 3,3,3,3.

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared header and package for the round-robin FIFO arbiter: flit width, requester count,
// pointer width, FSM state type and the saturating-counter helper (used when ARB_STATS_EN is defined).
`ifndef SIZE
`define SIZE 8
`endif
`ifndef ARB_N
`define ARB_N 4
`endif
`ifndef ARB_PTR_W
`define ARB_PTR_W 2
`endif

package fifo_rr_arbiter_pkg;

    localparam int ARB_SIZE      = `SIZE;
    localparam int ARB_N_DEF     = `ARB_N;
    localparam int ARB_PTR_W_DEF = `ARB_PTR_W;
    localparam int STAT_W        = 16;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] value);
        logic [STAT_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotates the request vector so the search begins just after
// the last winner, finds the first set bit, then maps it back to an absolute index modulo N.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last,
    output logic [N-1:0]     gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [PTR_W:0]   w_start;
    logic [N-1:0]     w_rot;
    logic [PTR_W:0]   w_off;
    logic             w_found;
    logic [PTR_W+1:0] w_sum;

    // Search start is last+1 modulo N; out-of-range pointers restart at requester 0.
    always_comb begin
        if ({1'b0, last} >= (PTR_W+1)'(N-1)) begin
            w_start = {(PTR_W+1){1'b0}};
        end else begin
            w_start = {1'b0, last} + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // Double-width rotate so the requester at w_start lands on bit 0.
    always_comb begin
        w_rot = N'({req, req} >> w_start);
    end

    // Lowest set bit of the rotated vector is the offset of the winner from w_start.
    always_comb begin
        w_off   = {(PTR_W+1){1'b0}};
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_off   = (PTR_W+1)'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Undo the rotation with a modulo-N add, never modulo 2^PTR_W.
    always_comb begin
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (PTR_W+2)'(N)) begin
            w_sum = w_sum - (PTR_W+2)'(N);
        end else begin
            w_sum = w_sum;
        end
        gnt_idx = w_sum[PTR_W-1:0];
        any     = |req;
        if (any) begin
            gnt_onehot = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
        end else begin
            gnt_onehot = {N{1'b0}};
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler sharing one output channel among N flit FIFOs through a single-entry
// valid/ready output register. Define ARB_STATS_EN to add per-requester saturating grant counters.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N     = ARB_N_DEF,
    parameter int PTR_W = ARB_PTR_W_DEF,
    parameter int SIZE  = ARB_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic [N-1:0]        i_fifo_empty,
    input  logic [N*SIZE-1:0]   i_fifo_item,
    output logic [N-1:0]        o_fifo_read,
    output logic                o_out_valid,
    output logic [SIZE-1:0]     o_out_data,
    input  logic                i_out_ready,
    output logic [PTR_W-1:0]    o_grant_id
`ifdef ARB_STATS_EN
    ,
    output logic [N*STAT_W-1:0] o_grant_count
`endif
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [PTR_W-1:0] r_last;
    logic [SIZE-1:0]  r_out_data;
    logic [PTR_W-1:0] r_grant_id;

    logic [N-1:0]     w_req;
    logic [N-1:0]     w_gnt_onehot;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_any;
    logic             w_slot_free;
    logic             w_grant;
    logic [SIZE-1:0]  w_item;

    assign w_req = ~i_fifo_empty;

    rr_priority_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req        (w_req),
        .last       (r_last),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // Grant qualification; reset is folded in so no FIFO is popped while it is held.
    always_comb begin
        w_slot_free = (r_state == ST_EMPTY) | i_out_ready;
        w_grant     = i_enable & w_slot_free & w_any & ~reset;
        if (w_grant) begin
            o_fifo_read = w_gnt_onehot;
        end else begin
            o_fifo_read = {N{1'b0}};
        end
    end

    // Head-flit mux for the winning FIFO.
    always_comb begin
        w_item = {SIZE{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_item = i_fifo_item[i*SIZE +: SIZE];
            end else begin
                w_item = w_item;
            end
        end
    end

    // Next-state logic: a grant always refills; an accepted flit with no refill empties the slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else if (i_out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register and pointer; last starts at N-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= {SIZE{1'b0}};
            r_grant_id <= {PTR_W{1'b0}};
            r_last     <= PTR_W'(N-1);
        end else if (w_grant) begin
            r_out_data <= w_item;
            r_grant_id <= w_gnt_idx;
            r_last     <= w_gnt_idx;
        end else begin
            r_out_data <= r_out_data;
            r_grant_id <= r_grant_id;
            r_last     <= r_last;
        end
    end

    assign o_out_valid = (r_state == ST_FULL);
    assign o_out_data  = r_out_data;
    assign o_grant_id  = r_grant_id;

`ifdef ARB_STATS_EN
    for (genvar g = 0; g < N; g++) begin : g_stats
        logic [STAT_W-1:0] r_cnt;

        // Per-requester grant counter, saturating at all-ones.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= {STAT_W{1'b0}};
            end else if (o_fifo_read[g]) begin
                r_cnt <= sat_inc16(r_cnt);
            end else begin
                r_cnt <= r_cnt;
            end
        end

        assign o_grant_count[g*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed self-checking bench for fifo_rr_arbiter with a behavioural model of four input FIFOs.
module tb_fifo_rr_arbiter;
    import fifo_rr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int SZ = ARB_SIZE;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            out_ready;
    logic [N-1:0]    fifo_empty;
    logic [N-1:0]    fifo_read;
    logic [N*SZ-1:0] fifo_item;
    logic            out_valid;
    logic [SZ-1:0]   out_data;
    logic [PW-1:0]   grant_id;
`ifdef ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    logic [SZ-1:0] mem [N][64];
    logic [5:0]    head [N] = '{default: 6'd0};
    logic [5:0]    tail [N] = '{default: 6'd0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.N(N), .PTR_W(PW), .SIZE(SZ)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_fifo_empty (fifo_empty),
        .i_fifo_item  (fifo_item),
        .o_fifo_read  (fifo_read),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .o_grant_id   (grant_id)
`ifdef ARB_STATS_EN
        ,
        .o_grant_count(grant_count)
`endif
    );

    for (genvar g = 0; g < N; g++) begin : g_fifo
        assign fifo_empty[g]           = (head[g] == tail[g]);
        assign fifo_item[g*SZ +: SZ]   = mem[g][head[g]];
    end

    // FIFO model pops on the strobe; popping an empty FIFO is a design error.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_read[i]) begin
                if (fifo_empty[i]) begin
                    bad = bad + 1;
                    $display("FAIL pop_empty fifo=%0d read=%b empty=%b", i, fifo_read, fifo_empty);
                end
                head[i] <= head[i] + 6'd1;
            end
        end
    end

    task automatic load(input int f, input logic [SZ-1:0] v);
        mem[f][tail[f]] = v;
        tail[f] = tail[f] + 6'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL rst_read got=%b exp=0000", fifo_read); end
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL idle_read c=%0d got=%b exp=0000", c, fifo_read); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid c=%0d got=%b exp=0", c, out_valid); end
            total++; if (out_data !== 8'h00) begin bad++; $display("FAIL idle_data c=%0d got=%h exp=00", c, out_data); end
            tick();
        end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL idle_gid got=%0d exp=0", grant_id); end
`ifdef ARB_STATS_EN
        total++; if (grant_count !== 64'd0) begin bad++; $display("FAIL stats_reset got=%h exp=0", grant_count); end
`endif
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_rd;
        logic [SZ-1:0] exp_d;
        for (int f = 0; f < N; f++) begin
            for (int k = 0; k < 3; k++) begin
                load(f, SZ'(f*16 + k));
            end
        end
        #1;
        for (int j = 0; j < 12; j++) begin
            exp_rd = 4'b0001 << (j % 4);
            exp_d  = SZ'((j % 4)*16 + j/4);
            total++; if (fifo_read !== exp_rd) begin bad++; $display("FAIL rr_read j=%0d got=%b exp=%b", j, fifo_read, exp_rd); end
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid j=%0d got=%b exp=1", j, out_valid); end
            total++; if (grant_id !== PW'(j % 4)) begin bad++; $display("FAIL rr_gid j=%0d got=%0d exp=%0d", j, grant_id, j % 4); end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL rr_data j=%0d got=%h exp=%h", j, out_data, exp_d); end
        end
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL rr_end_read got=%b exp=0000", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h32) begin bad++; $display("FAIL rr_hold_data got=%h exp=32", out_data); end
`ifdef ARB_STATS_EN
        total++; if (grant_count !== {16'd3, 16'd3, 16'd3, 16'd3}) begin bad++; $display("FAIL stats_rr got=%h exp=0003000300030003", grant_count); end
`endif
    endtask

    task automatic test_single();
        for (int k = 0; k < 5; k++) load(2, SZ'(8'hA0 + k));
        #1;
        for (int k = 0; k < 5; k++) begin
            total++; if (fifo_read !== 4'b0100) begin bad++; $display("FAIL single_read k=%0d got=%b exp=0100", k, fifo_read); end
            tick();
            total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_gid k=%0d got=%0d exp=2", k, grant_id); end
            total++; if (out_data !== SZ'(8'hA0 + k)) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, out_data, 8'hA0 + k); end
        end
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL single_end got=%b exp=0000", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] ids [3]  = '{2'd1, 2'd0, 2'd1};
        logic [SZ-1:0] dats [3] = '{8'h60, 8'h51, 8'h61};
        out_ready = 1'b0;
        load(0, 8'h50); load(0, 8'h51);
        load(1, 8'h60); load(1, 8'h61);
        #1;
        total++; if (fifo_read !== 4'b0001) begin bad++; $display("FAIL bp_first_read got=%b exp=0001", fifo_read); end
        tick();
        total++; if (out_data !== 8'h50 || grant_id !== 2'd0) begin bad++; $display("FAIL bp_first got=%h/%0d exp=50/0", out_data, grant_id); end
        for (int c = 0; c < 4; c++) begin
            total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL bp_stall_read c=%0d got=%b exp=0000", c, fifo_read); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h50 || grant_id !== 2'd0) begin
                bad++; $display("FAIL bp_stall_hold c=%0d got=%b/%h/%0d exp=1/50/0", c, out_valid, out_data, grant_id);
            end
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (fifo_read !== (4'b0001 << ids[k])) begin bad++; $display("FAIL bp_rel_read k=%0d got=%b exp=%b", k, fifo_read, 4'b0001 << ids[k]); end
            tick();
            total++; if (grant_id !== ids[k] || out_data !== dats[k]) begin
                bad++; $display("FAIL bp_rel k=%0d got=%0d/%h exp=%0d/%h", k, grant_id, out_data, ids[k], dats[k]);
            end
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_enable();
        out_ready = 1'b0;
        load(3, 8'h70); load(3, 8'h71);
        #1;
        total++; if (fifo_read !== 4'b1000) begin bad++; $display("FAIL en_first_read got=%b exp=1000", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h70) begin bad++; $display("FAIL en_first got=%b/%h exp=1/70", out_valid, out_data); end
        enable = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL en_low_read got=%b exp=0000", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h70) begin bad++; $display("FAIL en_drain got=%b/%h exp=0/70", out_valid, out_data); end
        for (int c = 0; c < 3; c++) begin
            total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL en_hold_read c=%0d got=%b exp=0000", c, fifo_read); end
            tick();
            total++; if (out_valid !== 1'b0 || fifo_empty[3] !== 1'b0) begin bad++; $display("FAIL en_hold c=%0d got=%b/%b exp=0/0", c, out_valid, fifo_empty[3]); end
        end
        enable = 1'b1;
        #1;
        total++; if (fifo_read !== 4'b1000) begin bad++; $display("FAIL en_resume_read got=%b exp=1000", fifo_read); end
        tick();
        total++; if (out_data !== 8'h71 || grant_id !== 2'd3) begin bad++; $display("FAIL en_resume got=%h/%0d exp=71/3", out_data, grant_id); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [N-1:0]  rds [3]  = '{4'b0001, 4'b0010, 4'b0100};
        logic [SZ-1:0] dats [3] = '{8'h80, 8'h83, 8'h82};
        load(1, 8'h81); load(1, 8'h83);
        #1;
        total++; if (fifo_read !== 4'b0010) begin bad++; $display("FAIL ar_first_read got=%b exp=0010", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h81) begin bad++; $display("FAIL ar_first got=%b/%h exp=1/81", out_valid, out_data); end
        load(0, 8'h80); load(2, 8'h82);
        #1;
        total++; if (fifo_read !== 4'b0100) begin bad++; $display("FAIL ar_pre_read got=%b exp=0100", fifo_read); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || grant_id !== 2'd0) begin
            bad++; $display("FAIL ar_async got=%b/%h/%0d exp=0/00/0", out_valid, out_data, grant_id);
        end
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL ar_rst_read got=%b exp=0000", fifo_read); end
        tick();
        total++; if (fifo_empty !== 4'b1000 || out_valid !== 1'b0) begin bad++; $display("FAIL ar_no_pop got=%b/%b exp=1000/0", fifo_empty, out_valid); end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (fifo_read !== rds[k]) begin bad++; $display("FAIL ar_read k=%0d got=%b exp=%b", k, fifo_read, rds[k]); end
            tick();
            total++; if (out_data !== dats[k]) begin bad++; $display("FAIL ar_data k=%0d got=%h exp=%h", k, out_data, dats[k]); end
        end
        total++; if (fifo_read !== 4'b0000) begin bad++; $display("FAIL ar_end_read got=%b exp=0000", fifo_read); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_end got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
